// File: rtl/gpr_wb_pkg.sv
// rtl/gpr_wb_pkg.sv - shared types and width helpers for the GPR writeback arbiter
//   commit_t : packed commit beat {wis, tmask, pc, wb, rd, sop, eop, data} at default widths
//   CDATAW   : packed width of commit_t
//   state_e  : arbiter FSM state {IDLE, LOCKED}
//   idx_w()  : source index width (never below 1)
//   cdata_w(): packed commit beat width for arbitrary parameters
package gpr_wb_pkg;

  localparam int DEF_NUM_SRCS    = 4;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_NR_BITS     = 6;
  localparam int DEF_PC_BITS     = 32;
  localparam int DEF_WIS_W       = 2;

  typedef struct packed {
    logic [DEF_WIS_W-1:0]                      wis;
    logic [DEF_NUM_THREADS-1:0]                tmask;
    logic [DEF_PC_BITS-1:0]                    pc;
    logic                                      wb;
    logic [DEF_NR_BITS-1:0]                    rd;
    logic                                      sop;
    logic                                      eop;
    logic [DEF_NUM_THREADS-1:0][DEF_XLEN-1:0]  data;
  } commit_t;

  localparam int CDATAW = $bits(commit_t);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cdata_w(input int nt, input int xlen, input int nr,
                                 input int pcb, input int wisw);
    return wisw + nt + pcb + 1 + nr + 2 + nt * xlen;
  endfunction

endpackage

// File: rtl/gpr_wb_rr_arbiter.sv
// rtl/gpr_wb_rr_arbiter.sv - round-robin grant selection with packet lock override
//   i_valid     : per-source beat valid
//   i_lock      : 1 while a multi-beat packet owns the output
//   i_lock_id   : owning source while locked
//   i_rr_ptr    : first source to consider when not locked
//   o_grant     : one-hot grant (all-0 when nothing eligible)
//   o_grant_idx : index of the granted source
module gpr_wb_rr_arbiter #(
  parameter int NUM_SRCS = 4,
  parameter int IDXW     = 2
) (
  input  logic [NUM_SRCS-1:0] i_valid,
  input  logic                i_lock,
  input  logic [IDXW-1:0]     i_lock_id,
  input  logic [IDXW-1:0]     i_rr_ptr,
  output logic [NUM_SRCS-1:0] o_grant,
  output logic [IDXW-1:0]     o_grant_idx
);

  logic            w_found;
  logic [IDXW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    if (i_lock) begin
      // The packet owner keeps the grant even when it has no beat this cycle,
      // so a bubble never lets another source slip into the middle of a packet.
      o_grant[i_lock_id] = 1'b1;
      o_grant_idx        = i_lock_id;
    end else begin
      for (int k = 0; k < NUM_SRCS; k++) begin
        w_idx = IDXW'((int'(i_rr_ptr) + k) % NUM_SRCS);
        if (!w_found && i_valid[w_idx]) begin
          w_found        = 1'b1;
          o_grant[w_idx] = 1'b1;
          o_grant_idx    = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - merges NUM_SRCS commit streams into one registered GPR writeback stream
//   clk, reset        : clock, synchronous active-low reset
//   commit_valid/data : per-source commit beats (packed commit layout, see gpr_wb_pkg)
//   commit_ready      : per-source accept, combinational
//   wb_*              : registered writeback beat, valid-only
//   perf_*            : beat / stall counters, live only with GPR_WB_ARB_PERF_EN defined
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter  int NUM_SRCS    = 4,
  parameter  int NUM_THREADS = 4,
  parameter  int XLEN        = 32,
  parameter  int NR_BITS     = 6,
  parameter  int PC_BITS     = 32,
  parameter  int WIS_W       = 2,
  localparam int CW          = cdata_w(NUM_THREADS, XLEN, NR_BITS, PC_BITS, WIS_W),
  localparam int IDXW        = idx_w(NUM_SRCS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRCS-1:0]         commit_valid,
  input  logic [NUM_SRCS*CW-1:0]      commit_data,
  output logic [NUM_SRCS-1:0]         commit_ready,
  output logic                        wb_valid,
  output logic [WIS_W-1:0]            wb_wis,
  output logic [NUM_THREADS-1:0]      wb_tmask,
  output logic [PC_BITS-1:0]          wb_pc,
  output logic [NR_BITS-1:0]          wb_rd,
  output logic                        wb_sop,
  output logic                        wb_eop,
  output logic [NUM_THREADS*XLEN-1:0] wb_data,
  output logic [31:0]                 perf_wb_count,
  output logic [31:0]                 perf_stall_count
);

  // Field offsets inside one packed commit beat (data occupies the low bits).
  localparam int DW     = NUM_THREADS * XLEN;
  localparam int EOP_B  = DW;
  localparam int SOP_B  = DW + 1;
  localparam int RD_LO  = DW + 2;
  localparam int WB_B   = RD_LO + NR_BITS;
  localparam int PC_LO  = WB_B + 1;
  localparam int TM_LO  = PC_LO + PC_BITS;
  localparam int WIS_LO = TM_LO + NUM_THREADS;

  state_e          r_state;
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_lock_id;

  logic                   w_locked;
  logic [NUM_SRCS-1:0]    w_grant;
  logic [IDXW-1:0]        w_gidx;
  logic [CW-1:0]          w_sel;
  logic                   w_xfer;
  logic                   w_emit;
  logic                   w_eop;
  logic                   w_sop;
  logic                   w_wb;
  logic [NR_BITS-1:0]     w_rd;
  logic [PC_BITS-1:0]     w_pc;
  logic [NUM_THREADS-1:0] w_tmask;
  logic [WIS_W-1:0]       w_wis;

  assign w_locked = (r_state == LOCKED);

  gpr_wb_rr_arbiter #(
    .NUM_SRCS (NUM_SRCS),
    .IDXW     (IDXW)
  ) u_rr_arb (
    .i_valid     (commit_valid),
    .i_lock      (w_locked),
    .i_lock_id   (r_lock_id),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign commit_ready = reset ? w_grant : '0;

  assign w_sel   = commit_data[int'(w_gidx)*CW +: CW];
  assign w_eop   = w_sel[EOP_B];
  assign w_sop   = w_sel[SOP_B];
  assign w_rd    = w_sel[RD_LO +: NR_BITS];
  assign w_wb    = w_sel[WB_B];
  assign w_pc    = w_sel[PC_LO +: PC_BITS];
  assign w_tmask = w_sel[TM_LO +: NUM_THREADS];
  assign w_wis   = w_sel[WIS_LO +: WIS_W];

  assign w_xfer = |(commit_valid & commit_ready);
  // Non-writing beats are still consumed so that packet framing advances.
  assign w_emit = w_xfer & w_wb & (|w_tmask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      wb_valid  <= 1'b0;
      wb_wis    <= '0;
      wb_tmask  <= '0;
      wb_pc     <= '0;
      wb_rd     <= '0;
      wb_sop    <= 1'b0;
      wb_eop    <= 1'b0;
      wb_data   <= '0;
    end else begin
      wb_valid <= w_emit;
      if (w_emit) begin
        wb_wis   <= w_wis;
        wb_tmask <= w_tmask;
        wb_pc    <= w_pc;
        wb_rd    <= w_rd;
        wb_sop   <= w_sop;
        wb_eop   <= w_eop;
        wb_data  <= w_sel[DW-1:0];
      end
      if (w_xfer) begin
        if (w_eop) begin
          r_state  <= IDLE;
          r_rr_ptr <= (w_gidx == IDXW'(NUM_SRCS - 1)) ? '0 : w_gidx + IDXW'(1);
        end else begin
          r_state   <= LOCKED;
          r_lock_id <= w_gidx;
        end
      end
    end
  end

`ifdef GPR_WB_ARB_PERF_EN
  logic [31:0] r_perf_wb;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_wb    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (wb_valid) begin
        r_perf_wb <= r_perf_wb + 32'd1;
      end
      if (|(commit_valid & ~commit_ready)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_wb_count    = r_perf_wb;
  assign perf_stall_count = r_perf_stall;
`else
  assign perf_wb_count    = '0;
  assign perf_stall_count = '0;
`endif

`ifndef SYNTHESIS
  a_no_sop_while_locked : assert property (@(posedge clk) disable iff (!reset)
    !(w_locked && w_xfer && w_sop));

  for (genvar s = 0; s < NUM_SRCS; s++) begin : g_hold_chk
    a_hold_while_stalled : assert property (@(posedge clk) disable iff (!reset)
      (commit_valid[s] && !commit_ready[s]) |=>
      (!commit_valid[s] || (commit_data[s*CW +: CW] == $past(commit_data[s*CW +: CW]))));
  end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - directed scoreboard bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  import gpr_wb_pkg::*;

`ifdef GPR_WB_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [3:0]    commit_valid;
  logic [4*CDATAW-1:0] commit_data;
  logic [3:0]    commit_ready;
  logic          wb_valid;
  logic [1:0]    wb_wis;
  logic [3:0]    wb_tmask;
  logic [31:0]   wb_pc;
  logic [5:0]    wb_rd;
  logic          wb_sop;
  logic          wb_eop;
  logic [127:0]  wb_data;
  logic [31:0]   perf_wb_count;
  logic [31:0]   perf_stall_count;

  gpr_wb_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .commit_valid     (commit_valid),
    .commit_data      (commit_data),
    .commit_ready     (commit_ready),
    .wb_valid         (wb_valid),
    .wb_wis           (wb_wis),
    .wb_tmask         (wb_tmask),
    .wb_pc            (wb_pc),
    .wb_rd            (wb_rd),
    .wb_sop           (wb_sop),
    .wb_eop           (wb_eop),
    .wb_data          (wb_data),
    .perf_wb_count    (perf_wb_count),
    .perf_stall_count (perf_stall_count)
  );

  int      n_assert = 0;
  int      n_fail   = 0;
  commit_t sb[$];
  commit_t beat[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic commit_t mk(input int src, input int seq, input bit wb,
                                 input logic [3:0] tm, input bit sop, input bit eop);
    commit_t m;
    m.wis   = 2'(src);
    m.tmask = tm;
    m.pc    = 32'h1000 + 32'(src * 256) + 32'(seq * 4);
    m.wb    = wb;
    m.rd    = 6'(src * 8 + seq);
    m.sop   = sop;
    m.eop   = eop;
    for (int l = 0; l < 4; l++) m.data[l] = 32'hA000_0000 | 32'(src << 16) | 32'(seq << 8) | 32'(l);
    return m;
  endfunction

  function automatic logic [255:0] pack_exp(input commit_t e);
    return 256'({e.wis, e.tmask, e.pc, e.rd, e.sop, e.eop, e.data});
  endfunction

  // One cycle: drive valids and current beats, check ready, queue expected writebacks.
  task automatic cyc(input logic [3:0] v, input logic [3:0] rdy, input string tag);
    @(posedge clk); #1;
    commit_valid = v;
    for (int s = 0; s < 4; s++) commit_data[s*CDATAW +: CDATAW] = beat[s];
    @(negedge clk);
    chk(tag, 256'(commit_ready), 256'(rdy));
    for (int s = 0; s < 4; s++)
      if (v[s] && rdy[s] && beat[s].wb && beat[s].tmask != 4'd0) sb.push_back(beat[s]);
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 256'(1), 256'(0));
      end else begin
        chk("wb_beat", 256'({wb_wis, wb_tmask, wb_pc, wb_rd, wb_sop, wb_eop, wb_data}),
            pack_exp(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    commit_valid = 4'h0;
    commit_data  = '0;
    for (int s = 0; s < 4; s++) beat[s] = mk(s, 0, 1'b1, 4'hF, 1'b1, 1'b1);

    // Reset: sources valid but nothing may be accepted.
    @(posedge clk); #1;
    commit_valid = 4'hF;
    for (int s = 0; s < 4; s++) commit_data[s*CDATAW +: CDATAW] = beat[s];
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 256'(commit_ready), 256'(0));
    chk("rst_wb_valid", 256'(wb_valid), 256'(0));
    chk("rst_wb_fields", 256'({wb_wis, wb_tmask, wb_pc, wb_rd, wb_sop, wb_eop, wb_data}), 256'(0));
    chk("rst_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));
    chk("rst_perf", 256'({perf_wb_count, perf_stall_count}), 256'(0));
    @(posedge clk); #1;
    commit_valid = 4'h0;
    reset = 1'b1;

    // Sources 0 and 2, single beats.
    beat[0] = mk(0, 1, 1'b1, 4'hF, 1'b1, 1'b1);
    beat[2] = mk(2, 1, 1'b1, 4'h5, 1'b1, 1'b1);
    cyc(4'b0101, 4'b0001, "t1_grant_src0");
    cyc(4'b0100, 4'b0100, "t1_grant_src2");
    cyc(4'b0000, 4'b0000, "t1_idle");
    chk("t1_rr_ptr", 256'(dut.r_rr_ptr), 256'(3));

    // Move rr_ptr to 1, then a 3-beat packet from src1 stalls src0.
    beat[3] = mk(3, 1, 1'b1, 4'h3, 1'b1, 1'b1);
    cyc(4'b1000, 4'b1000, "t2_setup_src3");
    beat[0] = mk(0, 2, 1'b1, 4'hF, 1'b1, 1'b1);
    cyc(4'b0001, 4'b0001, "t2_setup_src0");
    beat[0] = mk(0, 3, 1'b1, 4'hE, 1'b1, 1'b1);
    beat[1] = mk(1, 1, 1'b1, 4'hF, 1'b1, 1'b0);
    cyc(4'b0011, 4'b0010, "t2_beat0");
    beat[1] = mk(1, 2, 1'b1, 4'h7, 1'b0, 1'b0);
    cyc(4'b0011, 4'b0010, "t2_beat1");
    chk("t2_locked", 256'(dut.r_state), 256'(LOCKED));
    beat[1] = mk(1, 3, 1'b1, 4'h1, 1'b0, 1'b1);
    cyc(4'b0011, 4'b0010, "t2_beat2");
    cyc(4'b0001, 4'b0001, "t2_src0_after");
    cyc(4'b0000, 4'b0000, "t2_idle");
    chk("t2_rr_ptr", 256'(dut.r_rr_ptr), 256'(1));

    // src1 locked, drops valid for two cycles while src3 waits.
    beat[1] = mk(1, 4, 1'b1, 4'hF, 1'b1, 1'b0);
    beat[3] = mk(3, 2, 1'b1, 4'h9, 1'b1, 1'b1);
    cyc(4'b1010, 4'b0010, "t3_sop");
    cyc(4'b1000, 4'b0010, "t3_bubble0");
    cyc(4'b1000, 4'b0010, "t3_bubble1");
    chk("t3_bubble_wb0", 256'(wb_valid), 256'(0));
    beat[1] = mk(1, 5, 1'b1, 4'hC, 1'b0, 1'b1);
    cyc(4'b1010, 4'b0010, "t3_eop");
    chk("t3_bubble_wb1", 256'(wb_valid), 256'(0));
    cyc(4'b1000, 4'b1000, "t3_src3");
    cyc(4'b0000, 4'b0000, "t3_idle");
    chk("t3_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));

    // Non-writing beats: consumed, no writeback, fields held.
    beat[2] = mk(2, 2, 1'b0, 4'hF, 1'b1, 1'b1);
    cyc(4'b0100, 4'b0100, "t4_wb0_ready");
    cyc(4'b0000, 4'b0000, "t4_idle0");
    chk("t4_wb0_no_valid", 256'(wb_valid), 256'(0));
    chk("t4_wb0_rr_ptr", 256'(dut.r_rr_ptr), 256'(3));
    beat[3] = mk(3, 3, 1'b1, 4'h0, 1'b1, 1'b1);
    cyc(4'b1000, 4'b1000, "t4_tm0_ready");
    cyc(4'b0000, 4'b0000, "t4_idle1");
    chk("t4_tm0_no_valid", 256'(wb_valid), 256'(0));
    chk("t4_tm0_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));
    chk("t4_rd_held", 256'(wb_rd), 256'(mk(3, 2, 1'b1, 4'h9, 1'b1, 1'b1).rd));
    chk("t4_perf_wb", 256'(perf_wb_count), 256'(PERF ? 32'd11 : 32'd0));
    chk("t4_perf_stall", 256'(perf_stall_count), 256'(PERF ? 32'd8 : 32'd0));

    // Reset while locked with a writeback in flight.
    beat[1] = mk(1, 6, 1'b1, 4'hF, 1'b1, 1'b0);
    cyc(4'b0010, 4'b0010, "t5_sop");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready_in_reset", 256'(commit_ready), 256'(0));
    chk("t5_wb_valid_before", 256'(wb_valid), 256'(1));
    chk("t5_locked_before", 256'(dut.r_state), 256'(LOCKED));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_wb_valid_after", 256'(wb_valid), 256'(0));
    chk("t5_state_idle", 256'(dut.r_state), 256'(IDLE));
    chk("t5_rr_ptr", 256'(dut.r_rr_ptr), 256'(0));
    chk("t5_perf_zero", 256'({perf_wb_count, perf_stall_count}), 256'(0));
    chk("t5_ready_still0", 256'(commit_ready), 256'(0));
    @(posedge clk); #1;
    commit_valid = 4'h0;
    reset = 1'b1;

    // All four sources continuously valid, single beats.
    for (int s = 0; s < 4; s++) beat[s] = mk(s, 10, 1'b1, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 4'(1 << (i % 4)), $sformatf("t6_rr_%0d", i));
      beat[i % 4] = mk(i % 4, 11 + i, 1'b1, 4'hF, 1'b1, 1'b1);
    end
    cyc(4'b0000, 4'b0000, "t6_idle0");
    cyc(4'b0000, 4'b0000, "t6_idle1");
    chk("t6_perf_wb", 256'(perf_wb_count), 256'(PERF ? 32'd8 : 32'd0));
    chk("t6_perf_stall", 256'(perf_stall_count), 256'(PERF ? 32'd8 : 32'd0));

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
